apu_envelope_length: RTL
========================

Name: apu_envelope_length

Overview:
Per-channel envelope generator and length counter for the APU pulse/noise channels. It consumes the quarter-frame and half-frame square-wave clocks from frame_counter and edge-detects them into one-cycle events. Envelope decay runs on quarter-frame events and the length counter on half-frame events. Outputs a 4-bit channel volume and an active flag to the channel mixer.

Parameters:
VOL_W, 4, width of volume/envelope values
LEN_W, 8, width of length counter (max table value 254)

Ports:
clk  in  1  system clock, the same clock that drives frame_counter
rst  in  1  synchronous, active-high reset
fc_qfr_clk  in  1  quarter-frame square wave (~240 Hz) from frame_counter
fc_hfr_clk  in  1  half-frame square wave (~120 Hz) from frame_counter
enable  in  1  channel enable (status register bit)
halt  in  1  length-counter halt; doubles as envelope loop flag
const_vol  in  1  1 = output vol directly, 0 = output envelope decay level
vol  in  VOL_W  constant volume, or envelope divider period
len_idx  in  5  length table index
load  in  1  one-cycle strobe: load length and restart envelope
volume  out  VOL_W  channel volume to mixer (registered)
active  out  1  length counter nonzero

Behaviour:
- Reset: volume=0, active=0, length=0, decay=0, divider=0, start=0. While rst is high, qfr_d<=fc_qfr_clk and hfr_d<=fc_hfr_clk, so there is no spurious edge on release.
- Events: qfr_evt = fc_qfr_clk & ~qfr_d; hfr_evt = fc_hfr_clk & ~hfr_d. Each event is one cycle wide.
- frame_counter toggles fc_hfr_clk in the same cycle fc_qfr_clk rises, so a qfr_evt and an hfr_evt can coincide. Both are processed in that cycle.
- Length counter:
  - enable=0 forces length<=0 every cycle; load is ignored.
  - load & enable: length<=LEN_TABLE[len_idx]. If hfr_evt is in the same cycle, the load wins and there is no decrement that cycle.
  - hfr_evt & ~halt & length!=0: length<=length-1. No wrap below 0.
- Envelope:
  - load sets start<=1, independent of enable.
  - On qfr_evt with start=1: start<=0, decay<=15, divider<=vol.
  - On qfr_evt with start=0 and divider==0: divider<=vol; then if decay!=0, decay<=decay-1; else if halt, decay<=15; else decay stays 0.
  - On qfr_evt with start=0 and divider!=0: divider<=divider-1.
  - load in the same cycle as qfr_evt: the envelope evaluates the old start value. The new start=1 is consumed at the next qfr_evt.
- Outputs, registered with 1-cycle latency from internal state:
  - active <= (length_next != 0).
  - volume <= (length_next==0) ? 0 : (const_vol ? vol : decay_next).
- Field changes (vol, const_vol, halt) take effect at the next event; there is no shadowing.
- Reset mid-operation clears all state on the next clk edge. Events in that cycle are discarded.

Decomposition:
- Shared package apu_pkg holds LEN_TABLE, 32 x 8-bit: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30. It also holds VOL_MAX=15.
- One sub-module, apu_envelope, holds the start/divider/decay logic and qfr edge detect. The top level keeps the length counter, hfr edge detect and output muxing.

Test Plan:
- Reset with fc_qfr_clk=1 held, release -> no qfr_evt; volume=0, active=0.
- enable=1, halt=0, load with len_idx=3 (length 2), then 2 hfr rising edges -> active=1 after load; active=0 one cycle after the 2nd edge.
- const_vol=0, vol=0, halt=0, load, then 17 qfr edges -> volume=15 after 1st edge, 14 after 2nd, ... 0 after 16th; stays 0 after 17th.
- Same setup with halt=1 -> after decay reaches 0, the next qfr edge gives volume=15 (loop). Length is held, active stays 1.
- vol=2 divider check -> decay decrements once every 3 qfr edges after start.
- enable low while length=254 -> active=0 next cycle; load with enable=0 gives no reload. load coincident with an hfr edge -> length=table value, no decrement.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared constants for the APU channel blocks.
//   VOL_W / LEN_W : default widths of volume and length values
//   VOL_MAX       : envelope restart level
//   LEN_TABLE     : length-counter load values indexed by the 5-bit len_idx field
package apu_pkg;

  localparam int VOL_W   = 4;
  localparam int LEN_W   = 8;
  localparam int VOL_MAX = 15;

  localparam logic [7:0] LEN_TABLE [32] = '{
    8'd10,  8'd254, 8'd20, 8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
    8'd160, 8'd8,   8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
    8'd12,  8'd16,  8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
    8'd192, 8'd24,  8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30
  };

  function automatic logic [7:0] len_lookup(input logic [4:0] idx);
    return LEN_TABLE[idx];
  endfunction

endpackage

// File: rtl/apu_envelope.sv
// Envelope generator: quarter-frame edge detect, start flag, divider and
// decay level.
//   clk, rst     : clock, synchronous active-high reset
//   fc_qfr_clk   : quarter-frame square wave; rising edge = one envelope tick
//   load         : restart request, consumed at the next quarter-frame tick
//   halt         : loop flag; decay wraps from 0 back to VOL_MAX when set
//   vol          : divider period
//   decay_next   : decay level the register will hold after this edge
module apu_envelope
  import apu_pkg::*;
#(
  parameter int VOL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fc_qfr_clk,
  input  logic             load,
  input  logic             halt,
  input  logic [VOL_W-1:0] vol,
  output logic [VOL_W-1:0] decay_next
);

  logic             qfr_d;
  logic             qfr_evt;
  logic             start;
  logic             start_nx;
  logic [VOL_W-1:0] divider;
  logic [VOL_W-1:0] divider_nx;
  logic [VOL_W-1:0] decay;
  logic [VOL_W-1:0] decay_nx;

  assign qfr_evt = fc_qfr_clk & ~qfr_d;

  always_comb begin
    start_nx   = start;
    divider_nx = divider;
    decay_nx   = decay;
    if (qfr_evt) begin
      if (start) begin
        start_nx   = 1'b0;
        decay_nx   = VOL_W'(VOL_MAX);
        divider_nx = vol;
      end else if (divider == '0) begin
        divider_nx = vol;
        if (decay != '0) begin
          decay_nx = decay - 1'b1;
        end else if (halt) begin
          decay_nx = VOL_W'(VOL_MAX);
        end
      end else begin
        divider_nx = divider - 1'b1;
      end
    end
    // A load coinciding with a tick is not seen by that tick (it used the
    // old start above); the restart happens on the following tick.
    if (load) begin
      start_nx = 1'b1;
    end
  end

  assign decay_next = decay_nx;

  always_ff @(posedge clk) begin
    // Edge detector tracks the input even in reset so release is glitch-free.
    qfr_d <= fc_qfr_clk;
    if (rst) begin
      start   <= 1'b0;
      divider <= '0;
      decay   <= '0;
    end else begin
      start   <= start_nx;
      divider <= divider_nx;
      decay   <= decay_nx;
    end
  end

endmodule

// File: rtl/apu_envelope_length.sv
// Per-channel envelope + length counter for the pulse/noise channels.
//   clk, rst     : clock, synchronous active-high reset
//   fc_qfr_clk   : quarter-frame square wave (envelope tick on rising edge)
//   fc_hfr_clk   : half-frame square wave (length tick on rising edge)
//   enable       : channel enable; low forces length to 0
//   halt         : freezes length counter; envelope loop flag
//   const_vol    : 1 = output vol, 0 = output envelope decay
//   vol          : constant volume or envelope divider period
//   len_idx      : length table index
//   load         : one-cycle strobe, loads length and restarts envelope
//   volume       : registered channel volume
//   active       : registered length-nonzero flag
module apu_envelope_length
  import apu_pkg::*;
#(
  parameter int VOL_W = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fc_qfr_clk,
  input  logic             fc_hfr_clk,
  input  logic             enable,
  input  logic             halt,
  input  logic             const_vol,
  input  logic [VOL_W-1:0] vol,
  input  logic [4:0]       len_idx,
  input  logic             load,
  output logic [VOL_W-1:0] volume,
  output logic             active
);

  logic             hfr_d;
  logic             hfr_evt;
  logic [LEN_W-1:0] length;
  logic [LEN_W-1:0] length_nx;
  logic [VOL_W-1:0] decay_next;

  assign hfr_evt = fc_hfr_clk & ~hfr_d;

  apu_envelope #(.VOL_W(VOL_W)) u_env (
    .clk        (clk),
    .rst        (rst),
    .fc_qfr_clk (fc_qfr_clk),
    .load       (load),
    .halt       (halt),
    .vol        (vol),
    .decay_next (decay_next)
  );

  // Priority: disable, then load (a load beats a same-cycle half-frame
  // decrement), then decrement saturating at zero.
  always_comb begin
    length_nx = length;
    if (!enable) begin
      length_nx = '0;
    end else if (load) begin
      length_nx = LEN_W'(len_lookup(len_idx));
    end else if (hfr_evt && !halt && (length != '0)) begin
      length_nx = length - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    hfr_d <= fc_hfr_clk;
    if (rst) begin
      length <= '0;
      volume <= '0;
      active <= 1'b0;
    end else begin
      length <= length_nx;
      active <= (length_nx != '0);
      volume <= (length_nx == '0) ? '0 : (const_vol ? vol : decay_next);
    end
  end

endmodule
